// File: rtl/mem_block_mover_pkg.sv
// mem_block_mover_pkg
// Shared definitions for the block mover: FSM state encoding, default
// widths and the operation-mode constants seen on the 'mode' input.
package mem_block_mover_pkg;

  localparam int IDX_W_DEF  = 5;   // word index width (32-word memory)
  localparam int DATA_W_DEF = 32;  // memory data and address width

  localparam logic MODE_COPY = 1'b0;  // read src word, write it to dst
  localparam logic MODE_FILL = 1'b1;  // write fill pattern to dst

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_block_mover_addr.sv
// mem_addr_pack
// Maps a word index to the memory byte address. The index is replicated
// into two adjacent fields above the byte offset:
//   addr = {zeros, idx, idx, 2'b00}
// Ports:
//   idx  - word index
//   addr - byte address presented to the memory
module mem_addr_pack #(
  parameter int IDX_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] addr
);

  always_comb begin
    addr = '0;
    addr[2 +: IDX_W]         = idx;
    addr[2 + IDX_W +: IDX_W] = idx;
  end

endmodule

// File: rtl/mem_block_mover.sv
// mem_block_mover
// Moves a block of words inside a single-port memory. COPY reads a source
// word (RD) then writes it (WR), two cycles per word; FILL writes a latched
// pattern every cycle. Indices advance modulo the memory size, in strictly
// ascending order, so overlapping ranges propagate without correction.
//
// Handshake: 'start' is a one-cycle request that is only looked at in IDLE;
// it is accepted on the rising edge where it is high, busy rises in the
// next cycle and stays high until the one-cycle 'done' pulse (busy=0 then).
// A start seen while busy or in DONE is dropped, never queued.
//
// Ports:
//   clock, reset         - rising-edge clock, synchronous active-high reset
//   start, mode          - request strobe and operation (COPY/FILL)
//   src_idx, dst_idx     - first source / destination word index
//   len                  - word count 0..2^IDX_W
//   fill_data            - FILL pattern
//   busy, done           - operation status
//   xfer_cnt, checksum   - words written / XOR of words written
//   mem_sel..mem_wdata   - memory request; mem_rdata is same-cycle read data
//   dbg_state            - current FSM state
module mem_block_mover
  import mem_block_mover_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [IDX_W-1:0]  src_idx,
  input  logic [IDX_W-1:0]  dst_idx,
  input  logic [IDX_W:0]    len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [IDX_W:0]    xfer_cnt,
  output logic [DATA_W-1:0] checksum,
  output logic              mem_sel,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W:0]   CNT_ONE = (IDX_W + 1)'(1);

  state_t              state, next_state;
  logic                mode_q;
  logic [IDX_W-1:0]    src_q, dst_q;
  logic [IDX_W:0]      len_q;
  logic [DATA_W-1:0]   fill_q;
  logic [DATA_W-1:0]   data_q;

  logic [IDX_W:0]      cnt_inc;
  logic [IDX_W-1:0]    idx_sel;
  logic [DATA_W-1:0]   wr_word;
  logic [DATA_W-1:0]   addr_packed;
  logic                in_xfer;

  assign cnt_inc   = xfer_cnt + CNT_ONE;
  assign idx_sel   = (state == ST_RD) ? src_q : dst_q;
  assign wr_word   = (mode_q == MODE_FILL) ? fill_q : data_q;
  assign dbg_state = state;

  mem_addr_pack #(
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_addr (
    .idx  (idx_sel),
    .addr (addr_packed)
  );

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (len == '0)              next_state = ST_DONE;
          else if (mode == MODE_FILL) next_state = ST_WR;
          else                        next_state = ST_RD;
        end
      end
      ST_RD:   next_state = ST_WR;
      ST_WR: begin
        if (cnt_inc == len_q)         next_state = ST_DONE;
        else if (mode_q == MODE_COPY) next_state = ST_RD;
        else                          next_state = ST_WR;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are qualified with reset so an abort takes effect in the very
  // cycle reset is raised: the write that would otherwise land on the
  // reset edge is suppressed and no done pulse can escape.
  always_comb begin
    in_xfer   = ((state == ST_RD) || (state == ST_WR)) && !reset;
    busy      = in_xfer;
    done      = (state == ST_DONE) && !reset;
    mem_sel   = in_xfer;
    mem_wen   = in_xfer && (state == ST_WR);
    mem_addr  = in_xfer ? addr_packed : '0;
    mem_wdata = mem_wen ? wr_word : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      mode_q   <= MODE_COPY;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      fill_q   <= '0;
      data_q   <= '0;
      xfer_cnt <= '0;
      checksum <= '0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q   <= mode;
            src_q    <= src_idx;
            dst_q    <= dst_idx;
            len_q    <= len;
            fill_q   <= fill_data;
            xfer_cnt <= '0;
            checksum <= '0;
          end
        end
        ST_RD: data_q <= mem_rdata;
        ST_WR: begin
          xfer_cnt <= cnt_inc;
          checksum <= checksum ^ wr_word;
          src_q    <= src_q + IDX_ONE;
          dst_q    <= dst_q + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_block_mover.md
MEM_BLOCK_MOVER -- requirements
Module: mem_block_mover

Interface
REQ-001 SHALL have parameter IDX_W, default 5, meaning word-index width (32-word memory).
REQ-002 SHALL have parameter DATA_W, default 32, meaning memory data and address width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  single-cycle request; sampled only in IDLE.
REQ-007 mode  input  1  0 = COPY (read src, write dst); 1 = FILL (write fill_data to dst).
REQ-008 src_idx  input  IDX_W  first source word index, COPY only.
REQ-009 dst_idx  input  IDX_W  first destination word index.
REQ-010 len  input  IDX_W+1  word count, 0..32.
REQ-011 fill_data  input  DATA_W  FILL pattern.
REQ-012 busy  output  1  high from the cycle after an accepted start until DONE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 xfer_cnt  output  IDX_W+1  words written so far in the current or last operation.
REQ-015 checksum  output  DATA_W  XOR of all words written in the current or last operation.
REQ-016 mem_sel  output  1  memory select.
REQ-017 mem_addr  output  DATA_W  byte address to memory.
REQ-018 mem_wen  output  1  memory write enable.
REQ-019 mem_wdata  output  DATA_W  memory write data.
REQ-020 mem_rdata  input  DATA_W  memory read data; combinational from mem_addr, same cycle.

Function
REQ-021 SHALL implement FSM states IDLE, RD, WR, DONE.
REQ-022 IDLE: start=1 with len=0 SHALL go to DONE without any memory access.
REQ-023 IDLE: start=1, len>0 SHALL latch all operand inputs, clear xfer_cnt and checksum, and go to RD (COPY) or WR (FILL).
REQ-024 RD SHALL drive mem_sel=1, mem_wen=0, current src index, capture mem_rdata into a data register at the clock edge, and go to WR.
REQ-025 WR SHALL drive mem_sel=1, mem_wen=1, current dst index, mem_wdata = captured word (COPY) or fill_data latch (FILL).
REQ-026 Leaving WR SHALL increment xfer_cnt, XOR the written word into checksum, and increment both indices modulo 2^IDX_W (31 wraps to 0).
REQ-027 From WR SHALL go to DONE when xfer_cnt+1 == len, else to RD (COPY) or stay in WR (FILL).
REQ-028 COPY throughput SHALL be 2 cycles per word; FILL SHALL be 1 cycle per word.
REQ-029 DONE SHALL assert done for exactly one cycle, then return to IDLE; busy SHALL be 0 in DONE.
REQ-030 mem_addr SHALL be {zeros, idx, idx, 2'b00}: the word index in both bits [11:7] and [6:2].
REQ-031 Outside RD/WR: mem_sel=0, mem_wen=0, mem_addr=0, mem_wdata=0.
REQ-032 start during busy or DONE SHALL be ignored, with no queuing.
REQ-033 Overlapping src/dst ranges SHALL be processed strictly in ascending-index order, with no hazard correction.
REQ-034 xfer_cnt and checksum SHALL hold their final values until the next accepted start.

Reset
REQ-035 Reset SHALL force IDLE, with busy=0, done=0, xfer_cnt=0, checksum=0, and all mem_* outputs 0.
REQ-036 Reset mid-operation SHALL abort immediately; the aborted operation SHALL never assert done; memory writes already issued remain.

Structure
REQ-037 A shared package SHALL hold the state enum, IDX_W/DATA_W defaults, and MODE_COPY/MODE_FILL constants.
REQ-038 SHALL contain one sub-module, mem_addr_pack, which maps an index to mem_addr per REQ-030.

Verification
REQ-039 The bench SHALL pair the block with the 32x32 memory model; it SHALL preload word[k]=k*0x01010101 before each scenario.
REQ-040 COPY src=2, dst=10, len=4 -> words 10..13 = 0x02020202..0x05050505, done at cycle 9 after start, xfer_cnt=4, checksum = XOR of those four words.
REQ-041 FILL dst=30, len=4, fill=0xDEADBEEF -> words 30, 31, 0, 1 written (wrap), done at cycle 5, checksum=0.
REQ-042 start with len=0 -> no mem_sel asserted, done one cycle later, xfer_cnt=0.
REQ-043 start pulsed mid-COPY with different operands -> ignored, and the original result is unchanged.
REQ-044 Reset asserted in WR of the 2nd word of a len=8 COPY -> IDLE next cycle, no done, exactly one word written.
REQ-045 COPY src=0, dst=1, len=3 (overlap) -> words 1..3 all = 0x00000000 (ascending propagation).
